// File: rtl/rsa_xcel_naive_xcel_mgr.sv
// Accelerator-register front end for the naive RSA ModExp unit: decodes xcel
// register reads/writes, launches one job per go write and captures its result.
module rsa_xcel_naive_xcel_mgr (
  input  logic        clk,
  input  logic        reset,
  input  logic        xreq_val,
  output logic        xreq_rdy,
  input  logic        xreq_type,
  input  logic [4:0]  xreq_addr,
  input  logic [31:0] xreq_data,
  input  logic [7:0]  xreq_opaque,
  output logic        xresp_val,
  input  logic        xresp_rdy,
  output logic        xresp_type,
  output logic [31:0] xresp_data,
  output logic [7:0]  xresp_opaque,
  output logic [95:0] modexp_istream_msg,
  output logic        modexp_istream_val,
  input  logic        modexp_istream_rdy,
  input  logic [31:0] modexp_ostream_msg,
  input  logic        modexp_ostream_val,
  output logic        modexp_ostream_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] b_r;
  logic [31:0] e_r;
  logic [31:0] n_r;
  logic [31:0] result_r;
  logic [31:0] data_r;
  logic        type_r;
  logic [7:0]  opaque_r;
  logic [31:0] rd_data_s;

  // Read-data selection over the accelerator register map
  always_comb begin
    rd_data_s = 32'd0;
    case (xreq_addr)
      5'd0:    rd_data_s = result_r;
      5'd1:    rd_data_s = b_r;
      5'd2:    rd_data_s = e_r;
      5'd3:    rd_data_s = n_r;
      default: rd_data_s = 32'd0;
    endcase
  end

  // Transaction FSM together with the operand, result and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      b_r      <= 32'd0;
      e_r      <= 32'd0;
      n_r      <= 32'd0;
      result_r <= 32'd0;
      data_r   <= 32'd0;
      type_r   <= 1'b0;
      opaque_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xreq_val) begin
            type_r   <= xreq_type;
            opaque_r <= xreq_opaque;
            if (xreq_type) begin
              data_r <= 32'd0;
              case (xreq_addr)
                5'd1:    b_r <= xreq_data;
                5'd2:    e_r <= xreq_data;
                5'd3:    n_r <= xreq_data;
                default: b_r <= b_r;
              endcase
              // A go write holds its response until the job has finished
              state_r <= (xreq_addr == 5'd0) ? SEND : RESP;
            end else begin
              data_r  <= rd_data_s;
              state_r <= RESP;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (modexp_istream_rdy) begin
            state_r <= WAIT;
          end else begin
            state_r <= SEND;
          end
        end
        WAIT: begin
          if (modexp_ostream_val) begin
            result_r <= modexp_ostream_msg;
            state_r  <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (xresp_rdy) begin
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure state decodes, forced low while reset is held
  assign xreq_rdy           = reset && (state_r == IDLE);
  assign modexp_istream_val = reset && (state_r == SEND);
  assign modexp_ostream_rdy = reset && (state_r == WAIT);
  assign xresp_val          = reset && (state_r == RESP);

  assign xresp_type         = type_r;
  assign xresp_data         = data_r;
  assign xresp_opaque       = opaque_r;
  assign modexp_istream_msg = {n_r, e_r, b_r};

endmodule

// File: tb/tb_rsa_xcel_naive_xcel_mgr.sv
// Bench for rsa_xcel_naive_xcel_mgr: a host driver plus a behavioural ModExp
// unit with programmable stalls, both checked against a register-map model.
module tb_rsa_xcel_naive_xcel_mgr;

  logic        clk = 1'b0;
  logic        reset;
  logic        xreq_val;
  logic        xreq_rdy;
  logic        xreq_type;
  logic [4:0]  xreq_addr;
  logic [31:0] xreq_data;
  logic [7:0]  xreq_opaque;
  logic        xresp_val;
  logic        xresp_rdy;
  logic        xresp_type;
  logic [31:0] xresp_data;
  logic [7:0]  xresp_opaque;
  logic [95:0] modexp_istream_msg;
  logic        modexp_istream_val;
  logic        modexp_istream_rdy;
  logic [31:0] modexp_ostream_msg;
  logic        modexp_ostream_val;
  logic        modexp_ostream_rdy;

  int checks = 0;
  int failures = 0;

  // Register-map model: index 0 is the last result, 1..3 are b, e, n
  logic [31:0] m_reg [0:3];

  // ModExp unit model state
  int          in_stall = 0;
  int          out_stall = 0;
  bit          junk_en = 1'b0;
  int          jobs = 0;
  bit          me_busy = 1'b0;
  bit          me_first = 1'b0;
  int          me_cnt = 0;
  logic [95:0] held_msg;

  always #5 clk = ~clk;

  rsa_xcel_naive_xcel_mgr dut (
    .clk                (clk),
    .reset              (reset),
    .xreq_val           (xreq_val),
    .xreq_rdy           (xreq_rdy),
    .xreq_type          (xreq_type),
    .xreq_addr          (xreq_addr),
    .xreq_data          (xreq_data),
    .xreq_opaque        (xreq_opaque),
    .xresp_val          (xresp_val),
    .xresp_rdy          (xresp_rdy),
    .xresp_type         (xresp_type),
    .xresp_data         (xresp_data),
    .xresp_opaque       (xresp_opaque),
    .modexp_istream_msg (modexp_istream_msg),
    .modexp_istream_val (modexp_istream_val),
    .modexp_istream_rdy (modexp_istream_rdy),
    .modexp_ostream_msg (modexp_ostream_msg),
    .modexp_ostream_val (modexp_ostream_val),
    .modexp_ostream_rdy (modexp_ostream_rdy)
  );

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] n);
    longint unsigned r, x, m;
    if (n == 32'd0) return 32'd0;
    m = 64'(n);
    r = 64'd1 % m;
    x = 64'(b) % m;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[31:0];
  endfunction

  // Behavioural ModExp unit: acts at negedges on outputs that are stable until the next posedge
  initial begin
    modexp_istream_rdy = 1'b0;
    modexp_ostream_val = 1'b0;
    modexp_ostream_msg = 32'd0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        me_busy = 1'b0; me_first = 1'b0; me_cnt = 0;
        modexp_istream_rdy = 1'b0;
        modexp_ostream_val = 1'b0;
      end else if (!me_busy) begin
        modexp_ostream_val = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
        modexp_ostream_msg = $urandom;
        if (modexp_istream_val === 1'b1) begin
          if (me_cnt == 0) begin
            held_msg = modexp_istream_msg;
          end else begin
            checks++;
            if (modexp_istream_msg !== held_msg) begin
              failures++;
              $display("FAIL istream_msg_stable: got %h expected %h", modexp_istream_msg, held_msg);
            end
          end
          if (me_cnt < in_stall) begin
            modexp_istream_rdy = 1'b0;
            me_cnt++;
          end else begin
            modexp_istream_rdy = 1'b1;
            me_busy = 1'b1; me_first = 1'b1; me_cnt = 0;
            jobs++;
          end
        end else begin
          modexp_istream_rdy = 1'b0;
          me_cnt = 0;
        end
      end else begin
        modexp_istream_rdy = 1'b0;
        if (me_first) begin
          me_first = 1'b0;
          checks++;
          if (modexp_ostream_rdy !== 1'b1) begin
            failures++;
            $display("FAIL ostream_rdy_after_job: got %b expected 1", modexp_ostream_rdy);
          end
        end
        if (me_cnt < out_stall) begin
          modexp_ostream_val = 1'b0;
          me_cnt++;
        end else if (modexp_ostream_rdy === 1'b1) begin
          modexp_ostream_val = 1'b1;
          modexp_ostream_msg = modexp(held_msg[31:0], held_msg[63:32], held_msg[95:64]);
          me_busy = 1'b0; me_cnt = 0;
        end else begin
          modexp_ostream_val = 1'b0;
        end
      end
    end
  end

  // One complete xcel transaction checked against the model; obs returns the response data
  task automatic xact(input logic t, input logic [4:0] a, input logic [31:0] d,
                      input int rstall, input string nm, output logic [31:0] obs);
    logic [7:0]  op;
    logic [31:0] exp_d;
    logic [95:0] exp_msg;
    bit          go;
    int          cyc;
    int          jobs0;
    op    = 8'($urandom);
    go    = t && (a == 5'd0);
    exp_d = (t || a > 5'd3) ? 32'd0 : m_reg[a[1:0]];
    @(negedge clk);
    xreq_val = 1'b1; xreq_type = t; xreq_addr = a; xreq_data = d;
    xreq_opaque = op; xresp_rdy = 1'b0;
    cyc = 0;
    while (xreq_rdy !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (xreq_rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: xreq_rdy got %b expected 1", nm, xreq_rdy);
    end
    jobs0 = jobs;
    @(negedge clk);
    xreq_val = 1'b0; xreq_data = $urandom; xreq_addr = 5'($urandom);
    if (t && a >= 5'd1 && a <= 5'd3) m_reg[a[1:0]] = d;
    exp_msg = {m_reg[3], m_reg[2], m_reg[1]};
    if (go) m_reg[0] = modexp(m_reg[1], m_reg[2], m_reg[3]);
    checks++;
    if (go) begin
      if (modexp_istream_val !== 1'b1 || xresp_val !== 1'b0 || modexp_istream_msg !== exp_msg) begin
        failures++;
        $display("FAIL %s_launch: istream_val %b xresp_val %b msg %h expected 1 0 %h",
                 nm, modexp_istream_val, xresp_val, modexp_istream_msg, exp_msg);
      end
    end else if (xresp_val !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency: xresp_val got %b expected 1", nm, xresp_val);
    end
    cyc = 0;
    while (xresp_val !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
    for (int i = 0; i < rstall; i++) begin
      checks++;
      if (xresp_val !== 1'b1 || xresp_data !== exp_d || xreq_rdy !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold: val %b data %h rdy %b expected 1 %h 0",
                 nm, xresp_val, xresp_data, xreq_rdy, exp_d);
      end
      @(negedge clk);
    end
    xresp_rdy = 1'b1;
    obs = xresp_data;
    checks++;
    if (xresp_val !== 1'b1 || xresp_data !== exp_d || xresp_type !== t || xresp_opaque !== op) begin
      failures++;
      $display("FAIL %s_resp: val %b data %h type %b opaque %h expected 1 %h %b %h",
               nm, xresp_val, xresp_data, xresp_type, xresp_opaque, exp_d, t, op);
    end
    @(negedge clk);
    xresp_rdy = 1'b0;
    checks++;
    if (xresp_val !== 1'b0 || xreq_rdy !== 1'b1 || (go && jobs != jobs0 + 1)) begin
      failures++;
      $display("FAIL %s_done: xresp_val %b xreq_rdy %b jobs %0d expected 0 1 %0d",
               nm, xresp_val, xreq_rdy, jobs - jobs0, go ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (xreq_rdy !== 1'b0 || xresp_val !== 1'b0 || modexp_istream_val !== 1'b0 ||
          modexp_ostream_rdy !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: rdy %b rval %b ival %b ordy %b expected 0 0 0 0",
                 xreq_rdy, xresp_val, modexp_istream_val, modexp_ostream_rdy);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (xreq_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_rdy: got %b expected 1", xreq_rdy);
    end
    for (int a = 1; a <= 4; a++) xact(1'b0, 5'(a % 4), 32'd0, 0, "reset_read", obs);
  endtask

  task automatic test_modexp();
    logic [31:0] obs;
    xact(1'b1, 5'd1, 32'd4, 0, "wr_b", obs);
    xact(1'b1, 5'd2, 32'd13, 0, "wr_e", obs);
    xact(1'b1, 5'd3, 32'd497, 0, "wr_n", obs);
    xact(1'b1, 5'd0, 32'd0, 0, "go", obs);
    xact(1'b0, 5'd0, 32'd0, 0, "rd_result", obs);
    checks++;
    if (obs !== 32'd445) begin
      failures++;
      $display("FAIL modexp_known: got %0d expected 445", obs);
    end
  endtask

  task automatic test_stall();
    logic [31:0] obs;
    in_stall = 5; out_stall = 20;
    xact(1'b1, 5'd0, 32'd0, 0, "go_stall", obs);
    in_stall = 0; out_stall = 0;
    xact(1'b0, 5'd0, 32'd0, 0, "rd_result_stall", obs);
    checks++;
    if (obs !== 32'd445) begin
      failures++;
      $display("FAIL stall_result: got %0d expected 445", obs);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] obs;
    xact(1'b0, 5'd2, 32'd0, 3, "bp_read_e", obs);
    checks++;
    if (obs !== 32'd13) begin
      failures++;
      $display("FAIL bp_data: got %0d expected 13", obs);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] obs;
    xact(1'b1, 5'd7, 32'hDEAD, 0, "wr_xr7", obs);
    xact(1'b0, 5'd7, 32'd0, 0, "rd_xr7", obs);
    for (int a = 1; a <= 3; a++) xact(1'b0, 5'(a), 32'd0, 0, "rd_after_xr7", obs);
  endtask

  task automatic test_random();
    logic [31:0] obs;
    logic [4:0]  a;
    logic [31:0] d;
    logic        t;
    junk_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      in_stall  = $urandom_range(0, 4);
      out_stall = $urandom_range(0, 8);
      a = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
      t = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a == 5'd3 && d == 32'd0) d = 32'd1;
      xact(t, a, d, $urandom_range(0, 2), "random", obs);
    end
    junk_en = 1'b0; in_stall = 0; out_stall = 0;
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] obs;
    int          cyc;
    int          jobs0;
    out_stall = 40;
    jobs0 = jobs;
    @(negedge clk);
    xreq_val = 1'b1; xreq_type = 1'b1; xreq_addr = 5'd0; xreq_opaque = 8'h5A; xresp_rdy = 1'b1;
    @(negedge clk);
    xreq_val = 1'b0;
    cyc = 0;
    while (jobs == jobs0 && cyc < 50) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    checks++;
    if (modexp_ostream_rdy !== 1'b1) begin
      failures++;
      $display("FAIL mid_job_wait: ostream_rdy got %b expected 1", modexp_ostream_rdy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (xresp_val !== 1'b0 || modexp_istream_val !== 1'b0) begin
        failures++;
        $display("FAIL mid_job_no_resp: xresp_val %b istream_val %b expected 0 0",
                 xresp_val, modexp_istream_val);
      end
    end
    xresp_rdy = 1'b0; out_stall = 0;
    xact(1'b0, 5'd0, 32'd0, 0, "rd_result_after_reset", obs);
    xact(1'b0, 5'd1, 32'd0, 0, "rd_b_after_reset", obs);
  endtask

  initial begin
    reset = 1'b0; xreq_val = 1'b0; xreq_type = 1'b0; xreq_addr = 5'd0;
    xreq_data = 32'd0; xreq_opaque = 8'd0; xresp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
    test_reset();
    test_modexp();
    test_stall();
    test_backpressure();
    test_unmapped();
    test_random();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
